data_mem_pipe: RTL and testbench
================================

Name: data_mem_pipe

Overview:
Parametrised data memory for the pipelined ARM datapath, serving the MEM stage.
- Adds a valid/ready request port, byte-enable writes and a configurable registered read latency.
- Flags out-of-range accesses instead of aliasing them.
- Clears its contents after reset with a sequential init engine.
- One request is accepted per cycle; only reads produce a response.

Parameters:
DATA_W, 64, data word width in bits; multiple of 8.
DEPTH, 16, number of words; power of two, 2..65536.
ADDR_W, 64, request address width; word address, not byte address.
READ_LAT, 1, cycles from accepted read to RESP_VALID; legal 1..4.
INIT_CLEAR, 1, 1 = zero all words after reset before accepting requests; 0 = skip init.

Ports:
CLK  input  1  system clock; all state changes on posedge.
RST_N  input  1  asynchronous active-low reset.
REQ_VALID  input  1  request present this cycle.
REQ_READY  output  1  block can accept a request this cycle.
REQ_WRITE  input  1  1 = write, 0 = read.
REQ_ADDR  input  ADDR_W  word address.
REQ_WDATA  input  DATA_W  write data.
REQ_BE  input  DATA_W/8  byte enables; bit i controls bits [8i+7:8i].
RESP_VALID  output  1  one-cycle pulse per accepted read.
RESP_DATA  output  DATA_W  read data; 0 when RESP_VALID=0.
RESP_ERR  output  1  read address was out of range; qualified by RESP_VALID.
WR_ERR  output  1  sticky flag; an out-of-range write was dropped.
INIT_DONE  output  1  init complete; memory contents valid.

Behaviour:
- Reset (RST_N low, async): FSM to INIT (INIT_CLEAR=1) or READY (INIT_CLEAR=0).
  - Outputs during reset: REQ_READY=0, RESP_VALID=0, RESP_DATA=0, RESP_ERR=0, WR_ERR=0, INIT_DONE=0.
  - All read-pipeline stages are invalidated.
  - The memory array itself is not reset.
- FSM states: INIT, READY.
  - INIT: counter runs 0..DEPTH-1; word[counter] is written to 0, one word per cycle.
  - INIT to READY on the cycle after word DEPTH-1 is cleared; init therefore takes DEPTH cycles.
  - READY: INIT_DONE=1, REQ_READY=1. The block stays in READY until reset.
  - With INIT_CLEAR=0, INIT_DONE and REQ_READY rise on the first posedge after reset is released.
- Accept: a request is accepted when REQ_VALID && REQ_READY at posedge. REQ_VALID is ignored while REQ_READY=0.
- Range check: in range iff REQ_ADDR < DEPTH; the full ADDR_W-bit value is compared.
- Write, in range: at the accepting edge, each byte i with REQ_BE[i]=1 takes REQ_WDATA byte i; other bytes are unchanged.
  - REQ_BE=0 writes nothing and is not an error.
- Write, out of range: no array change; WR_ERR set to 1 at the accepting edge and held until reset.
- Read, accepted at edge N: RESP_VALID=1 for exactly the cycle following edge N+READ_LAT-1.
  - READ_LAT=1 means valid in the cycle right after acceptance.
  - RESP_DATA holds the word value after all writes accepted before edge N; a write accepted at edge N is not visible to that read.
  - Out of range: RESP_DATA=0, RESP_ERR=1.
  - Array read is registered at acceptance; later stages are a shift pipeline of {valid, err, data}.
- Throughput: back-to-back reads every cycle give back-to-back RESP_VALID in order. There is no response backpressure.
- Read-after-write: a read accepted the cycle after a write to the same address returns the new data, because the write commits at its accept edge.
- Reset mid-operation: in-flight reads are discarded with no response; init restarts from word 0.
- Width rules: DATA_W/8 byte lanes; the index uses the low log2(DEPTH) bits only after the range check passes.

Test Plan:
- Reset, DEPTH=16, INIT_CLEAR=1, release RST_N -> REQ_READY=0 for 16 cycles, then INIT_DONE=REQ_READY=1; reads of addr 0..15 all return 0 with RESP_ERR=0.
- Write addr 7 = 'h00AA with BE=8'hFF, then next cycle read addr 7, READ_LAT=1 -> RESP_VALID one cycle later, RESP_DATA='h00AA.
- Write addr 5 = 'hFFFF_FFFF_FFFF_FFFF, then write addr 5 = 'h1122 with BE=8'h01, then read -> 'hFFFF_FFFF_FFFF_FF22.
- Read addr 16 and addr 'h1_0000_0000 -> RESP_VALID with RESP_ERR=1, RESP_DATA=0; write addr 20 -> WR_ERR=1 stays high, memory unchanged.
- READ_LAT=3, reads to addrs 0,1,2 on consecutive cycles after writing 'h15, 'hC4, 'h33 -> RESP_VALID on 3 consecutive cycles starting 3 cycles after the first accept, data 'h15, 'hC4, 'h33 in order.
- Assert RST_N low with 2 reads in flight -> RESP_VALID=0 immediately, no late responses, WR_ERR cleared, init restarts (16 cycles of REQ_READY=0).

Source files
------------

// File: rtl/data_mem_pipe_if.sv
// -----------------------------------------------------------------------------
// data_mem_pipe_if
// Request/response bundle for the MEM-stage data memory (data_mem_pipe).
//
// Signals
//   REQ_VALID   request present this cycle
//   REQ_READY   memory can accept a request this cycle
//   REQ_WRITE   1 = write, 0 = read
//   REQ_ADDR    word address (ADDR_W bits)
//   REQ_WDATA   write data (DATA_W bits)
//   REQ_BE      byte enables, bit i covers data bits [8i+7:8i]
//   RESP_VALID  one-cycle pulse per accepted read
//   RESP_DATA   read data, zero while RESP_VALID is low
//   RESP_ERR    the read address was out of range (qualified by RESP_VALID)
//   WR_ERR      sticky: an out-of-range write was dropped
//   INIT_DONE   contents initialised, requests may be issued
//
// Modports
//   master  requester side (pipeline MEM stage)
//   slave   memory side
// -----------------------------------------------------------------------------
interface data_mem_pipe_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic                  REQ_VALID;
    logic                  REQ_READY;
    logic                  REQ_WRITE;
    logic [ADDR_W-1:0]     REQ_ADDR;
    logic [DATA_W-1:0]     REQ_WDATA;
    logic [DATA_W/8-1:0]   REQ_BE;
    logic                  RESP_VALID;
    logic [DATA_W-1:0]     RESP_DATA;
    logic                  RESP_ERR;
    logic                  WR_ERR;
    logic                  INIT_DONE;

    modport master (
        output REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_WDATA, REQ_BE,
        input  REQ_READY, RESP_VALID, RESP_DATA, RESP_ERR, WR_ERR, INIT_DONE
    );

    modport slave (
        input  REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_WDATA, REQ_BE,
        output REQ_READY, RESP_VALID, RESP_DATA, RESP_ERR, WR_ERR, INIT_DONE
    );
endinterface

// File: rtl/data_mem_pipe.sv
// -----------------------------------------------------------------------------
// data_mem_pipe
// Data memory for the MEM stage of the pipelined ARM datapath. Accepts one
// valid/ready request per cycle, supports byte-enable writes, returns reads
// after READ_LAT cycles, flags out-of-range accesses instead of aliasing them,
// and optionally zeroes the whole array after reset before taking requests.
//
// Parameters
//   DATA_W      data word width, multiple of 8
//   DEPTH       number of words, power of two, 2..65536
//   ADDR_W      request (word) address width
//   READ_LAT    accept-to-RESP_VALID latency, 1..4
//   INIT_CLEAR  1 = clear all words after reset, 0 = ready right away
//
// Ports
//   CLK    system clock, rising edge
//   RST_N  asynchronous active-low reset
//   bus    data_mem_pipe_if slave modport (request and response signals)
//
// FSM
//   state    | meaning
//   ST_INIT  | init engine zeroes word[init_cnt_q], one word per cycle
//   ST_READY | requests accepted; held until the next reset
// -----------------------------------------------------------------------------
module data_mem_pipe #(
    parameter int DATA_W     = 64,
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 64,
    parameter int READ_LAT   = 1,
    parameter bit INIT_CLEAR = 1'b1
) (
    input  logic           CLK,
    input  logic           RST_N,
    data_mem_pipe_if.slave bus
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BE_W  = DATA_W / 8;
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [IDX_W-1:0]  init_cnt_q;
    logic              done_q;

    logic              init_we;
    logic              req_ready;
    logic              init_done;

    logic              accept;
    logic              acc_rd;
    logic              acc_wr;
    logic              in_range;
    logic [IDX_W-1:0]  idx;

    logic              wr_err_q;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              pv_q [READ_LAT];
    logic              pe_q [READ_LAT];
    logic [DATA_W-1:0] pd_q [READ_LAT];

    // ------------------------------------------------------------------
    // FSM: state register
    // done_q is registered from the next state so that, even when reset
    // lands directly in ST_READY (INIT_CLEAR=0), READY/INIT_DONE stay low
    // during reset and rise on the first edge after release.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            if (INIT_CLEAR) begin
                state_q <= ST_INIT;
            end else begin
                state_q <= ST_READY;
            end
            init_cnt_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_d == ST_READY);
            if (state_q == ST_INIT) begin
                init_cnt_q <= init_cnt_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if ((state_q == ST_INIT) && (init_cnt_q == LAST_IDX)) begin
            state_d = ST_READY;
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        init_we   = 1'b0;
        req_ready = 1'b0;
        init_done = 1'b0;
        if (state_q == ST_INIT) begin
            init_we = 1'b1;
        end
        if (done_q) begin
            req_ready = 1'b1;
            init_done = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Request decode. The full address is compared against DEPTH so that
    // high address bits never alias onto a valid word; the low index bits
    // are only used once the range check has passed.
    // ------------------------------------------------------------------
    assign accept   = bus.REQ_VALID && req_ready;
    assign acc_wr   = accept && bus.REQ_WRITE;
    assign acc_rd   = accept && !bus.REQ_WRITE;
    assign in_range = (bus.REQ_ADDR < DEPTH_A);
    assign idx      = bus.REQ_ADDR[IDX_W-1:0];

    // ------------------------------------------------------------------
    // Storage. Not reset; the init engine clears it when enabled. Init
    // writes and request writes never overlap since requests are only
    // accepted once done_q is set.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (init_we) begin
            mem[init_cnt_q] <= '0;
        end else if (acc_wr && in_range) begin
            for (int i = 0; i < BE_W; i++) begin
                if (bus.REQ_BE[i]) begin
                    mem[idx][8*i +: 8] <= bus.REQ_WDATA[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Sticky dropped-write flag
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_err_q <= 1'b0;
        end else if (acc_wr && !in_range) begin
            wr_err_q <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline. Stage 0 samples the array at the accept edge, so a
    // write committed on an earlier edge is visible. Data and error are
    // forced to zero in empty slots so RESP_DATA/RESP_ERR are clean
    // whenever RESP_VALID is low.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < READ_LAT; i++) begin
                pv_q[i] <= 1'b0;
                pe_q[i] <= 1'b0;
                pd_q[i] <= '0;
            end
        end else begin
            pv_q[0] <= acc_rd;
            pe_q[0] <= acc_rd && !in_range;
            pd_q[0] <= (acc_rd && in_range) ? mem[idx] : '0;
            for (int i = 1; i < READ_LAT; i++) begin
                pv_q[i] <= pv_q[i-1];
                pe_q[i] <= pe_q[i-1];
                pd_q[i] <= pd_q[i-1];
            end
        end
    end

    assign bus.REQ_READY  = req_ready;
    assign bus.INIT_DONE  = init_done;
    assign bus.WR_ERR     = wr_err_q;
    assign bus.RESP_VALID = pv_q[READ_LAT-1];
    assign bus.RESP_ERR   = pe_q[READ_LAT-1];
    assign bus.RESP_DATA  = pd_q[READ_LAT-1];

endmodule

// File: tb/tb_data_mem_pipe.sv
// -----------------------------------------------------------------------------
// tb_data_mem_pipe
// Directed bench for data_mem_pipe. Two instances (READ_LAT=1 and READ_LAT=3,
// both DEPTH=16, INIT_CLEAR=1) receive the same request stream so latency
// behaviour of both can be compared against hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_data_mem_pipe;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_be;

    int checks   = 0;
    int failures = 0;

    data_mem_pipe_if #(.ADDR_W(64), .DATA_W(64)) bus1 ();
    data_mem_pipe_if #(.ADDR_W(64), .DATA_W(64)) bus3 ();

    assign bus1.REQ_VALID = req_valid;
    assign bus1.REQ_WRITE = req_write;
    assign bus1.REQ_ADDR  = req_addr;
    assign bus1.REQ_WDATA = req_wdata;
    assign bus1.REQ_BE    = req_be;
    assign bus3.REQ_VALID = req_valid;
    assign bus3.REQ_WRITE = req_write;
    assign bus3.REQ_ADDR  = req_addr;
    assign bus3.REQ_WDATA = req_wdata;
    assign bus3.REQ_BE    = req_be;

    data_mem_pipe #(.DATA_W(64), .DEPTH(16), .ADDR_W(64), .READ_LAT(1), .INIT_CLEAR(1'b1))
        u_lat1 (.CLK(clk), .RST_N(rst_n), .bus(bus1));

    data_mem_pipe #(.DATA_W(64), .DEPTH(16), .ADDR_W(64), .READ_LAT(3), .INIT_CLEAR(1'b1))
        u_lat3 (.CLK(clk), .RST_N(rst_n), .bus(bus3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs change and
    // outputs are sampled here, well away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic v, input logic w, input logic [63:0] a,
                           input logic [63:0] d, input logic [7:0] be);
        req_valid = v;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
    endtask

    task automatic set_idle();
        set_req(1'b0, 1'b0, 64'h0, 64'h0, 8'h00);
    endtask

    task automatic test_reset();
        int  n;
        logic seen;
        checks++;
        if (bus1.REQ_READY !== 1'b0) begin
            failures++; $display("FAIL rst_ready actual=%b expected=0", bus1.REQ_READY);
        end
        checks++;
        if (bus1.INIT_DONE !== 1'b0) begin
            failures++; $display("FAIL rst_init_done actual=%b expected=0", bus1.INIT_DONE);
        end
        checks++;
        if (bus1.RESP_VALID !== 1'b0 || bus3.RESP_VALID !== 1'b0) begin
            failures++; $display("FAIL rst_resp_valid actual=%b/%b expected=0/0", bus1.RESP_VALID, bus3.RESP_VALID);
        end
        checks++;
        if (bus1.RESP_DATA !== 64'h0 || bus1.RESP_ERR !== 1'b0) begin
            failures++; $display("FAIL rst_resp_data actual=%h err=%b expected=0", bus1.RESP_DATA, bus1.RESP_ERR);
        end
        checks++;
        if (bus1.WR_ERR !== 1'b0) begin
            failures++; $display("FAIL rst_wr_err actual=%b expected=0", bus1.WR_ERR);
        end
        rst_n = 1'b1;
        n = 0;
        seen = 1'b0;
        while (n < 40 && !seen) begin
            step();
            n++;
            if (bus1.REQ_READY === 1'b1) seen = 1'b1;
        end
        checks++;
        if (n !== 16) begin
            failures++; $display("FAIL init_cycles actual=%0d expected=16", n);
        end
        checks++;
        if (bus1.INIT_DONE !== 1'b1 || bus3.REQ_READY !== 1'b1) begin
            failures++; $display("FAIL init_done actual=%b/%b expected=1/1", bus1.INIT_DONE, bus3.REQ_READY);
        end
    endtask

    task automatic test_init_reads();
        for (int a = 0; a < 16; a++) begin
            set_req(1'b1, 1'b0, 64'(a), 64'h0, 8'h00);
            step();
            checks++;
            if (bus1.RESP_VALID !== 1'b1 || bus1.RESP_DATA !== 64'h0 || bus1.RESP_ERR !== 1'b0) begin
                failures++;
                $display("FAIL init_read addr=%0d actual v=%b d=%h e=%b expected v=1 d=0 e=0",
                         a, bus1.RESP_VALID, bus1.RESP_DATA, bus1.RESP_ERR);
            end
        end
        set_idle();
        repeat (4) step();
    endtask

    task automatic test_write_read();
        set_req(1'b1, 1'b1, 64'd7, 64'h00AA, 8'hFF);
        step();
        checks++;
        if (bus1.RESP_VALID !== 1'b0) begin
            failures++; $display("FAIL write_no_resp actual=%b expected=0", bus1.RESP_VALID);
        end
        set_req(1'b1, 1'b0, 64'd7, 64'h0, 8'h00);
        step();
        checks++;
        if (bus1.RESP_VALID !== 1'b1 || bus1.RESP_DATA !== 64'h00AA || bus1.RESP_ERR !== 1'b0) begin
            failures++;
            $display("FAIL raw_read7 actual v=%b d=%h e=%b expected v=1 d=00aa e=0",
                     bus1.RESP_VALID, bus1.RESP_DATA, bus1.RESP_ERR);
        end
        set_idle();
        step();
        checks++;
        if (bus1.RESP_VALID !== 1'b0 || bus1.RESP_DATA !== 64'h0) begin
            failures++;
            $display("FAIL resp_pulse actual v=%b d=%h expected v=0 d=0", bus1.RESP_VALID, bus1.RESP_DATA);
        end
        repeat (3) step();
    endtask

    task automatic test_byte_enable();
        set_req(1'b1, 1'b1, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        step();
        set_req(1'b1, 1'b1, 64'd5, 64'h0000_0000_0000_1122, 8'h01);
        step();
        set_req(1'b1, 1'b0, 64'd5, 64'h0, 8'h00);
        step();
        checks++;
        if (bus1.RESP_VALID !== 1'b1 || bus1.RESP_DATA !== 64'hFFFF_FFFF_FFFF_FF22) begin
            failures++;
            $display("FAIL be_lane0 actual v=%b d=%h expected v=1 d=ffffffffffffff22",
                     bus1.RESP_VALID, bus1.RESP_DATA);
        end
        set_req(1'b1, 1'b1, 64'd5, 64'h0, 8'h00);
        step();
        set_req(1'b1, 1'b1, 64'd5, 64'h3300_0000_0000_0000, 8'h80);
        step();
        checks++;
        if (bus1.WR_ERR !== 1'b0) begin
            failures++; $display("FAIL be_zero_no_err actual=%b expected=0", bus1.WR_ERR);
        end
        set_req(1'b1, 1'b0, 64'd5, 64'h0, 8'h00);
        step();
        checks++;
        if (bus1.RESP_VALID !== 1'b1 || bus1.RESP_DATA !== 64'h33FF_FFFF_FFFF_FF22) begin
            failures++;
            $display("FAIL be_lane7 actual v=%b d=%h expected v=1 d=33ffffffffffff22",
                     bus1.RESP_VALID, bus1.RESP_DATA);
        end
        set_idle();
        repeat (4) step();
    endtask

    task automatic test_range_err();
        set_req(1'b1, 1'b0, 64'd16, 64'h0, 8'h00);
        step();
        checks++;
        if (bus1.RESP_VALID !== 1'b1 || bus1.RESP_ERR !== 1'b1 || bus1.RESP_DATA !== 64'h0) begin
            failures++;
            $display("FAIL rd_oor16 actual v=%b e=%b d=%h expected v=1 e=1 d=0",
                     bus1.RESP_VALID, bus1.RESP_ERR, bus1.RESP_DATA);
        end
        set_req(1'b1, 1'b0, 64'h1_0000_0007, 64'h0, 8'h00);
        step();
        checks++;
        if (bus1.RESP_VALID !== 1'b1 || bus1.RESP_ERR !== 1'b1 || bus1.RESP_DATA !== 64'h0) begin
            failures++;
            $display("FAIL rd_oor_high actual v=%b e=%b d=%h expected v=1 e=1 d=0",
                     bus1.RESP_VALID, bus1.RESP_ERR, bus1.RESP_DATA);
        end
        set_req(1'b1, 1'b0, 64'd15, 64'h0, 8'h00);
        step();
        checks++;
        if (bus1.RESP_VALID !== 1'b1 || bus1.RESP_ERR !== 1'b0 || bus1.RESP_DATA !== 64'h0) begin
            failures++;
            $display("FAIL rd_last actual v=%b e=%b d=%h expected v=1 e=0 d=0",
                     bus1.RESP_VALID, bus1.RESP_ERR, bus1.RESP_DATA);
        end
        checks++;
        if (bus1.WR_ERR !== 1'b0) begin
            failures++; $display("FAIL wr_err_pre actual=%b expected=0", bus1.WR_ERR);
        end
        set_req(1'b1, 1'b1, 64'd20, 64'hDEAD, 8'hFF);
        step();
        checks++;
        if (bus1.WR_ERR !== 1'b1) begin
            failures++; $display("FAIL wr_err_set actual=%b expected=1", bus1.WR_ERR);
        end
        set_req(1'b1, 1'b1, 64'h1_0000_0007, 64'h55, 8'hFF);
        step();
        set_req(1'b1, 1'b0, 64'd4, 64'h0, 8'h00);
        step();
        checks++;
        if (bus1.RESP_DATA !== 64'h0 || bus1.RESP_ERR !== 1'b0) begin
            failures++; $display("FAIL oor_no_alias4 actual d=%h e=%b expected d=0 e=0", bus1.RESP_DATA, bus1.RESP_ERR);
        end
        set_req(1'b1, 1'b0, 64'd7, 64'h0, 8'h00);
        step();
        checks++;
        if (bus1.RESP_DATA !== 64'h00AA) begin
            failures++; $display("FAIL oor_no_alias7 actual=%h expected=00aa", bus1.RESP_DATA);
        end
        set_idle();
        repeat (3) step();
        checks++;
        if (bus1.WR_ERR !== 1'b1 || bus3.WR_ERR !== 1'b1) begin
            failures++; $display("FAIL wr_err_sticky actual=%b/%b expected=1/1", bus1.WR_ERR, bus3.WR_ERR);
        end
    endtask

    task automatic test_back_to_back();
        logic        e1v [6];
        logic        e3v [6];
        logic [63:0] e1d [6];
        logic [63:0] e3d [6];
        e1v = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        e1d = '{64'h15, 64'hC4, 64'h33, 64'h0, 64'h0, 64'h0};
        e3v = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        e3d = '{64'h0, 64'h0, 64'h15, 64'hC4, 64'h33, 64'h0};
        set_req(1'b1, 1'b1, 64'd0, 64'h15, 8'hFF);
        step();
        set_req(1'b1, 1'b1, 64'd1, 64'hC4, 8'hFF);
        step();
        set_req(1'b1, 1'b1, 64'd2, 64'h33, 8'hFF);
        step();
        for (int c = 0; c < 6; c++) begin
            if (c < 3) set_req(1'b1, 1'b0, 64'(c), 64'h0, 8'h00);
            else       set_idle();
            step();
            checks++;
            if (bus3.RESP_VALID !== e3v[c] || bus3.RESP_DATA !== e3d[c]) begin
                failures++;
                $display("FAIL b2b_lat3 cyc=%0d actual v=%b d=%h expected v=%b d=%h",
                         c, bus3.RESP_VALID, bus3.RESP_DATA, e3v[c], e3d[c]);
            end
            checks++;
            if (bus1.RESP_VALID !== e1v[c] || bus1.RESP_DATA !== e1d[c]) begin
                failures++;
                $display("FAIL b2b_lat1 cyc=%0d actual v=%b d=%h expected v=%b d=%h",
                         c, bus1.RESP_VALID, bus1.RESP_DATA, e1v[c], e1d[c]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int   n;
        logic seen;
        logic late;
        set_req(1'b1, 1'b0, 64'd0, 64'h0, 8'h00);
        step();
        set_req(1'b1, 1'b0, 64'd1, 64'h0, 8'h00);
        step();
        set_idle();
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus3.RESP_VALID !== 1'b0 || bus1.RESP_VALID !== 1'b0) begin
            failures++; $display("FAIL midrst_valid actual=%b/%b expected=0/0", bus1.RESP_VALID, bus3.RESP_VALID);
        end
        checks++;
        if (bus1.WR_ERR !== 1'b0 || bus1.REQ_READY !== 1'b0 || bus1.INIT_DONE !== 1'b0) begin
            failures++;
            $display("FAIL midrst_flags actual wr_err=%b ready=%b done=%b expected 0/0/0",
                     bus1.WR_ERR, bus1.REQ_READY, bus1.INIT_DONE);
        end
        step();
        step();
        rst_n = 1'b1;
        n = 0;
        seen = 1'b0;
        late = 1'b0;
        while (n < 40 && !seen) begin
            step();
            n++;
            if (bus1.RESP_VALID === 1'b1 || bus3.RESP_VALID === 1'b1) late = 1'b1;
            if (bus1.REQ_READY === 1'b1) seen = 1'b1;
        end
        checks++;
        if (n !== 16) begin
            failures++; $display("FAIL midrst_init_cycles actual=%0d expected=16", n);
        end
        checks++;
        if (late !== 1'b0) begin
            failures++; $display("FAIL midrst_late_resp actual=%b expected=0", late);
        end
        set_req(1'b1, 1'b0, 64'd7, 64'h0, 8'h00);
        step();
        checks++;
        if (bus1.RESP_VALID !== 1'b1 || bus1.RESP_DATA !== 64'h0) begin
            failures++;
            $display("FAIL midrst_cleared actual v=%b d=%h expected v=1 d=0", bus1.RESP_VALID, bus1.RESP_DATA);
        end
        set_idle();
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        set_idle();
        repeat (3) step();
        test_reset();
        test_init_reads();
        test_write_read();
        test_byte_enable();
        test_range_err();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
